// File: rtl/ref_particle_fetch.sv
// Read sequencer for the refx/refy/refz position RAMs: issues credit-limited reads,
// tracks the fixed read latency and buffers {x,y,z,id} for a valid/ready consumer.
module ref_particle_fetch #(
  parameter int unsigned DEPTH       = 512,
  parameter int unsigned ADDR_WIDTH  = $clog2(DEPTH),
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned RAM_LATENCY = 2,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   particle_num,
  output logic [ADDR_WIDTH-1:0] ref_address,
  output logic                  ref_rden,
  output logic                  ref_wren,
  input  logic [DATA_WIDTH-1:0] refx_q,
  input  logic [DATA_WIDTH-1:0] refy_q,
  input  logic [DATA_WIDTH-1:0] refz_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_x,
  output logic [DATA_WIDTH-1:0] out_y,
  output logic [DATA_WIDTH-1:0] out_z,
  output logic [ADDR_WIDTH-1:0] out_id,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = CW + 1;
  localparam int unsigned EW = 3 * DATA_WIDTH + ADDR_WIDTH;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e                state;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH:0]   num_q;
  logic [ADDR_WIDTH:0]   issue_idx;

  logic [RAM_LATENCY-1:0] pipe_vld;
  logic [ADDR_WIDTH-1:0]  pipe_id [RAM_LATENCY];
  logic [SW-1:0]          inflight;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] fifo_count;
  logic [EW-1:0] head;
  logic          push, pop;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RAM_LATENCY; i++) begin
      inflight = inflight + SW'(pipe_vld[i]);
    end
  end

  // Credit: reads still in the RAM pipe already own a FIFO slot.
  assign ref_rden    = (state == StIssue) &&
                       ((inflight + SW'(fifo_count)) < SW'(FIFO_DEPTH));
  assign ref_address = ref_rden ? (base_q + issue_idx[ADDR_WIDTH-1:0]) : '0;
  assign ref_wren    = 1'b0;

  assign push = pipe_vld[RAM_LATENCY-1];
  assign pop  = out_valid && out_ready;

  assign busy = (state != StIdle);
  assign done = (state == StDone);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      base_q    <= '0;
      num_q     <= '0;
      issue_idx <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (start) begin
            base_q    <= base_addr;
            num_q     <= particle_num;
            issue_idx <= '0;
            // An empty request passes through one drain cycle before done.
            state     <= (particle_num == '0) ? StDrain : StIssue;
          end
        end
        StIssue: begin
          if (ref_rden) begin
            issue_idx <= issue_idx + (ADDR_WIDTH + 1)'(1);
            if (issue_idx == num_q - (ADDR_WIDTH + 1)'(1)) state <= StDrain;
          end
        end
        StDrain: begin
          if (inflight == '0 && fifo_count == '0) state <= StDone;
        end
        StDone:  state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= ref_rden;
      for (int i = 1; i < RAM_LATENCY; i++) pipe_vld[i] <= pipe_vld[i-1];
    end
  end

  always_ff @(posedge clk) begin
    pipe_id[0] <= issue_idx[ADDR_WIDTH-1:0];
    for (int i = 1; i < RAM_LATENCY; i++) pipe_id[i] <= pipe_id[i-1];
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {refx_q, refy_q, refz_q, pipe_id[RAM_LATENCY-1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign head      = mem[rptr];
  assign out_valid = (fifo_count != '0);
  // Stale storage is masked so the data outputs read 0 whenever nothing is valid.
  assign out_x  = out_valid ? head[EW-1 -: DATA_WIDTH] : '0;
  assign out_y  = out_valid ? head[EW-DATA_WIDTH-1 -: DATA_WIDTH] : '0;
  assign out_z  = out_valid ? head[ADDR_WIDTH+DATA_WIDTH-1 -: DATA_WIDTH] : '0;
  assign out_id = out_valid ? head[ADDR_WIDTH-1:0] : '0;

endmodule

// File: tb/tb_ref_particle_fetch.sv
// Scoreboard bench for ref_particle_fetch with a 2-cycle registered RAM model
// holding x=a, y=2a, z=3a at address a.
module tb_ref_particle_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [8:0]  base_addr;
  logic [9:0]  particle_num;
  logic [8:0]  ref_address;
  logic        ref_rden, ref_wren;
  logic [31:0] refx_q, refy_q, refz_q;
  logic        out_valid, out_ready;
  logic [31:0] out_x, out_y, out_z;
  logic [8:0]  out_id;
  logic        busy, done;

  ref_particle_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .base_addr    (base_addr),
    .particle_num (particle_num),
    .ref_address  (ref_address),
    .ref_rden     (ref_rden),
    .ref_wren     (ref_wren),
    .refx_q       (refx_q),
    .refy_q       (refy_q),
    .refz_q       (refz_q),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_x        (out_x),
    .out_y        (out_y),
    .out_z        (out_z),
    .out_id       (out_id),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // RAM model: registered address, registered output.
  logic [8:0] ram_addr_q = '0;
  always @(posedge clk) begin
    if (ref_rden) ram_addr_q <= ref_address;
    refx_q <= 32'(ram_addr_q);
    refy_q <= 32'(ram_addr_q) * 2;
    refz_q <= 32'(ram_addr_q) * 3;
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cyc, first_rden, first_valid, last_valid, done_cyc;
  int rden_cnt, valid_cnt, done_cnt;
  logic [104:0] sq[$];
  logic [8:0]   aq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Monitor: compares issued addresses and accepted beats against the queues.
  always @(negedge clk) begin
    logic [104:0] e;
    logic [8:0]   a;
    cyc++;
    if (!rst) begin
      if (ref_rden) begin
        rden_cnt++;
        if (first_rden < 0) first_rden = cyc;
        if (aq.size() == 0) chk("rden_unexpected", 1, 0);
        else begin
          a = aq.pop_front();
          chk("ref_address", 64'(ref_address), 64'(a));
        end
      end
      if (out_valid) begin
        valid_cnt++;
        if (first_valid < 0) first_valid = cyc;
        last_valid = cyc;
      end
      if (out_valid && out_ready) begin
        if (sq.size() == 0) chk("beat_unexpected", 1, 0);
        else begin
          e = sq.pop_front();
          chk("beat_x", 64'(out_x), 64'(e[104:73]));
          chk("beat_y", 64'(out_y), 64'(e[72:41]));
          chk("beat_z", 64'(out_z), 64'(e[40:9]));
          chk("beat_id", 64'(out_id), 64'(e[8:0]));
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic go(input int b, input int n);
    int a;
    for (int i = 0; i < n; i++) begin
      a = (b + i) % 512;
      sq.push_back({32'(a), 32'(2 * a), 32'(3 * a), 9'(i)});
      aq.push_back(9'(a));
    end
    rden_cnt = 0; valid_cnt = 0; done_cnt = 0;
    first_rden = -1; first_valid = -1; last_valid = -1; done_cyc = -1;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 9'(b); particle_num = 10'(n);
    @(posedge clk);
    start_cyc = cyc;
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    chk(name, 64'(done_cnt != 0), 1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string name);
    chk(name, {ref_address, ref_rden, ref_wren, out_valid, out_x, out_id, busy, done}, '0);
    chk({name, "_yz"}, {out_y, out_z}, '0);
  endtask

  task automatic check_t1(input string tag);
    chk({tag, "_first_rden"}, 64'(first_rden - start_cyc), 1);
    chk({tag, "_first_valid"}, 64'(first_valid - start_cyc), 4);
    chk({tag, "_valid_cycles"}, 64'(valid_cnt), 8);
    chk({tag, "_contiguous"}, 64'(last_valid - first_valid), 7);
    chk({tag, "_rden_cnt"}, 64'(rden_cnt), 8);
    chk({tag, "_done_cnt"}, 64'(done_cnt), 1);
    chk({tag, "_sb_empty"}, 64'(sq.size() + aq.size()), 0);
    chk({tag, "_idle"}, {busy, done}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; particle_num = '0; out_ready = 1'b0;
    #3;
    check_reset_outputs("reset");
    @(posedge clk); #1 rst = 1'b0;

    // T1: straight run, always ready
    out_ready = 1'b1;
    go(0, 8);
    chk("t1_busy", 64'(busy), 1);
    wait_done("t1_done_seen", 100);
    check_t1("t1");

    // T2: address wrap
    go(510, 4);
    wait_done("t2_done_seen", 100);
    chk("t2_rden_cnt", 64'(rden_cnt), 4);
    chk("t2_done_cnt", 64'(done_cnt), 1);
    chk("t2_sb_empty", 64'(sq.size() + aq.size()), 0);

    // T3: backpressure
    out_ready = 1'b0;
    go(100, 16);
    repeat (20) @(posedge clk);
    #1;
    chk("t3_rden_stall", 64'(rden_cnt), 4);
    chk("t3_valid_stall", 64'(out_valid), 1);
    chk("t3_head_id", 64'(out_id), 0);
    out_ready = 1'b1;
    wait_done("t3_done_seen", 200);
    chk("t3_rden_cnt", 64'(rden_cnt), 16);
    chk("t3_done_cnt", 64'(done_cnt), 1);
    chk("t3_sb_empty", 64'(sq.size() + aq.size()), 0);

    // T4: empty request
    go(7, 0);
    wait_done("t4_done_seen", 20);
    chk("t4_done_latency", 64'(done_cyc - start_cyc), 2);
    chk("t4_rden_cnt", 64'(rden_cnt), 0);
    chk("t4_valid_cnt", 64'(valid_cnt), 0);
    chk("t4_done_cnt", 64'(done_cnt), 1);

    // T5: start re-pulsed mid-run must be ignored
    go(20, 6);
    repeat (2) @(posedge clk);
    #1 start = 1'b1; base_addr = 9'd300; particle_num = 10'd2;
    @(posedge clk); #1 start = 1'b0;
    wait_done("t5_done_seen", 100);
    repeat (6) @(posedge clk);
    #1;
    chk("t5_rden_cnt", 64'(rden_cnt), 6);
    chk("t5_done_cnt", 64'(done_cnt), 1);
    chk("t5_sb_empty", 64'(sq.size() + aq.size()), 0);

    // T6: reset while issuing with a full FIFO, then a clean rerun
    out_ready = 1'b0;
    go(0, 16);
    repeat (10) @(posedge clk);
    #1;
    chk("t6_full_rden", 64'(rden_cnt), 4);
    chk("t6_full_valid", 64'(out_valid), 1);
    #1 rst = 1'b1;
    #1;
    check_reset_outputs("t6_reset");
    sq.delete();
    aq.delete();
    @(posedge clk); #1 rst = 1'b0;
    out_ready = 1'b1;
    go(0, 8);
    wait_done("t6_done_seen", 100);
    check_t1("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
